mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port 4 KB memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipeline.
- Accesses take a configurable number of wait cycles.
- Each requester gets a registered req/ack handshake plus a combinational stall, which the hazard logic ORs into PC_Write, IFID_Write and the pipeline-register enables.

Parameters:
- ADDR_W, 12, byte address width of memory and requesters.
- LAT, 1, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  ADDR_W  fetch byte address; word-aligned.
- if_rdata  out  32  fetched word; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req & ~if_ack.
- dm_req  in  1  data request; held with all dm_* inputs until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_mode  in  2  access size (word/half/byte), passed to memory unchanged.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  raw load data, before memExtender; valid while dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for data.
- dm_stall  out  1  dm_req & ~dm_ack.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  32  memory write data.
- mem_we  out  1  memory write strobe.
- mem_mode  out  2  memory access size.
- mem_dout  in  32  memory read data; combinational from mem_addr/mem_mode.
- busy  out  1  high in BUSY and RESP.

Behaviour:
- Reset: state=IDLE, cnt=0, grant=IF, last_grant=IF. All outputs 0: mem_addr, mem_din, mem_we, mem_mode, if_ack, dm_ack, if_rdata, dm_rdata, busy.
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE; mem_we=0.
  - Any request present: select a winner, latch its addr/mode/we/wdata into the mem_* registers, load cnt=LAT-1, go to BUSY.
  - A fetch latches mode=word, we=0.
- Arbitration (default build): fixed priority, dm over if. The older instruction always wins.
- BUSY:
  - mem_addr, mem_mode and mem_din stay constant for the whole state.
  - cnt decrements each cycle while nonzero.
  - mem_we=1 only in the BUSY cycle where cnt==0, and only for a dm store. Exactly one write edge per store.
  - At cnt==0: register mem_dout into the granted requester's rdata, set that requester's ack=1, go to RESP.
  - The non-granted rdata register holds its value.
- RESP:
  - The granted ack is high for exactly this one cycle, then clears.
  - Go to IDLE unconditionally. This gives one mandatory bubble cycle between transactions.
  - The requester deasserts req or presents a new request at the RESP edge.
- Latency: req seen in IDLE at cycle N → ack high in cycle N+LAT+1. LAT=1 gives 2-cycle latency.
- Simultaneous if_req and dm_req in IDLE: one is granted. The loser stays stalled and is served from the next IDLE, with no request lost.
- A req asserted during BUSY/RESP is not sampled until IDLE.
- Requester inputs changing while req is high and ack has not arrived: undefined. The bench asserts this never happens.
- Requester dropping req mid-BUSY: the transaction still completes and the ack is still issued (ignored by the requester).
- if_ack and dm_ack are never high together.
- Asynchronous reset mid-BUSY: immediate return to IDLE with mem_we=0 and acks=0. A store aborted before its cnt==0 cycle writes nothing.
- cnt width: 4 bits; no wrap occurs because it is loaded at most 14.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration on ties.
  - last_grant updates at each grant.
  - When both request, the winner is the requester that was not last_grant.
  - last_grant resets to IF, so the first tie still goes to dm.
  - A single requester is always granted.
- Undefined: fixed dm-over-if priority; last_grant register absent.

Test Plan:
- Reset, then if_req=1 with if_addr=0x004 and mem word 0x8C010000 (LAT=1): if_ack high exactly 2 cycles after req; if_rdata=0x8C010000; if_stall high for 2 cycles.
- dm store, dm_we=1, dm_addr=0x010, dm_wdata=0xDEADBEEF, mode=word (LAT=3): mem_we high exactly one cycle, 3 cycles after grant. A following load from 0x010 returns dm_rdata=0xDEADBEEF.
- if_req and dm_req asserted in the same cycle, both held: dm_ack first, then if_ack exactly LAT+2 cycles later. With ARB_RR_EN, a second back-to-back tie grants if first.
- LAT=4 store in flight; pulse rst after 2 BUSY cycles: memory at the address unchanged, all outputs 0, state IDLE; a new fetch then completes normally.
- Continuous if_req plus a dm_req arriving mid-BUSY of a fetch: the fetch completes, and the dm request is granted at the next IDLE; busy deasserts for exactly one cycle between the two transactions.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and data requesters.
// Define ARB_RR_EN for round-robin tie breaking; default is dm-over-if priority.
module mem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_mode,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_we,
  output logic [1:0]        mem_mode,
  input  logic [31:0]       mem_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [3:0] CNT_INIT  = 4'(LAT - 1);
  localparam logic       ONE_CYC   = (LAT == 1);

  state_t     state;
  logic [3:0] cnt;
  logic       grant;
  logic       st_we;
  logic       dm_win;

`ifdef ARB_RR_EN
  logic last_grant;

  assign dm_win = dm_req & (~if_req | ~last_grant);
`else
  assign dm_win = dm_req;
`endif

  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      grant    <= 1'b0;
      st_we    <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      mem_mode <= '0;
      if_ack   <= 1'b0;
      dm_ack   <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      busy     <= 1'b0;
`ifdef ARB_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (if_req | dm_req) begin
            state <= BUSY;
            busy  <= 1'b1;
            cnt   <= CNT_INIT;
            grant <= dm_win;
`ifdef ARB_RR_EN
            last_grant <= dm_win;
`endif
            if (dm_win) begin
              mem_addr <= dm_addr;
              mem_mode <= dm_mode;
              mem_din  <= dm_wdata;
              st_we    <= dm_we;
              // the strobe must already be up in the first BUSY cycle
              mem_we   <= dm_we & ONE_CYC;
            end else begin
              mem_addr <= if_addr;
              mem_mode <= MODE_WORD;
              st_we    <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            mem_we <= 1'b0;
            state  <= RESP;
            if (grant) begin
              dm_rdata <= mem_dout;
              dm_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_dout;
              if_ack   <= 1'b1;
            end
          end else begin
            cnt    <= cnt - 4'd1;
            mem_we <= st_we & (cnt == 4'd1);
          end
        end
        RESP: begin
          if_ack <= 1'b0;
          dm_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed bench for mem_port_arbiter.
// A cycle-count reference model predicts every output each cycle.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 12;
  localparam int LAT    = 3;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;
  logic              if_stall;
  logic              dm_req;
  logic              dm_we;
  logic [1:0]        dm_mode;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [31:0]       dm_rdata;
  logic              dm_ack;
  logic              dm_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [1:0]        mem_mode;
  logic [31:0]       mem_dout;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_mode(dm_mode),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_mode(mem_mode), .mem_dout(mem_dout), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_we === 1'b1) we_cnt++;

  // memory environment with a preload port used during reset
  logic        load_en;
  logic [9:0]  load_idx;
  logic [31:0] load_val;
  logic [31:0] mem [0:1023];

  assign mem_dout = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_val;
    else if (mem_we) mem[mem_addr[11:2]] <= mem_din;
  end

  // reference model: transactions scheduled by cycle number
  logic [31:0] ref_mem [0:1023];
  int          idle_at, if_done, dm_done, we_cyc, b_lo, b_hi;
  logic [11:0] m_addr;
  logic [1:0]  m_mode;
  logic [31:0] m_din, e_if, e_dm;
  bit          m_st, last_dm, eia, eda, dw;

  always @(negedge clk) begin
    if (load_en) ref_mem[load_idx] = load_val;
    if (rst) begin
      idle_at = cyc + 1;
      if_done = -1; dm_done = -1; we_cyc = -1;
      b_lo = 0; b_hi = -1;
      e_if = '0; e_dm = '0;
      m_addr = '0; m_mode = '0; m_din = '0;
      m_st = 1'b0; last_dm = 1'b0;
    end else begin
      if (cyc == dm_done) begin
        e_dm = ref_mem[m_addr[11:2]];
        if (m_st) ref_mem[m_addr[11:2]] = m_din;
      end
      if (cyc == if_done) e_if = ref_mem[m_addr[11:2]];
    end
    eia = (cyc == if_done);
    eda = (cyc == dm_done);
    check("if_ack", if_ack, eia);
    check("dm_ack", dm_ack, eda);
    check("ack_excl", if_ack & dm_ack, 0);
    check("busy", busy, (cyc >= b_lo && cyc <= b_hi));
    check("mem_we", mem_we, (cyc == we_cyc));
    check("if_rdata", if_rdata, e_if);
    check("dm_rdata", dm_rdata, e_dm);
    check("mem_addr", mem_addr, m_addr);
    check("mem_mode", mem_mode, m_mode);
    check("mem_din", mem_din, m_din);
    check("if_stall", if_stall, if_req & ~eia);
    check("dm_stall", dm_stall, dm_req & ~eda);
    if (!rst && cyc >= idle_at && (if_req || dm_req)) begin
      dw = dm_req && (!if_req || !RR || !last_dm);
      last_dm = dw;
      b_lo = cyc + 1;
      b_hi = cyc + LAT + 1;
      idle_at = cyc + LAT + 2;
      if (dw) begin
        m_addr = dm_addr; m_mode = dm_mode;
        m_din = dm_wdata; m_st = dm_we;
        we_cyc = dm_we ? cyc + LAT : -1;
        dm_done = cyc + LAT + 1;
      end else begin
        m_addr = if_addr; m_mode = 2'b10; m_st = 1'b0;
        we_cyc = -1;
        if_done = cyc + LAT + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any(output bit got_dm, output int n);
    n = 0;
    @(negedge clk);
    while (!if_ack && !dm_ack && n < 40) begin
      n++;
      @(negedge clk);
    end
    got_dm = dm_ack;
    if (n >= 40) check("ack_timeout", 1, 0);
  endtask

  bit g, ia, da;
  int n, w0, gap;

  initial begin
    rst = 1'b1; load_en = 1'b0; load_idx = '0; load_val = '0;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_mode = 2'b10; dm_addr = '0; dm_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      load_en = 1'b1;
      load_idx = 10'(i);
      load_val = (i == 1) ? 32'h8C01_0000 :
                 (i == 8) ? 32'hA5A5_0008 : $urandom;
    end
    step();
    load_en = 1'b0;
    step();
    rst = 1'b0;
    step();

    // single fetch
    if_addr = 12'h004; if_req = 1;
    wait_any(g, n);
    check("t1_lat", n, LAT + 1);
    check("t1_who", g, 0);
    check("t1_rdata", if_rdata, 32'h8C01_0000);
    step(); if_req = 0;

    // store then load back
    step();
    w0 = we_cnt;
    dm_addr = 12'h010; dm_wdata = 32'hDEAD_BEEF; dm_we = 1; dm_mode = 2'b10;
    dm_req = 1;
    wait_any(g, n);
    check("t2_lat", n, LAT + 1);
    check("t2_who", g, 1);
    check("t2_we_pulses", we_cnt - w0, 1);
    step(); dm_we = 0;
    wait_any(g, n);
    check("t2_load", dm_rdata, 32'hDEAD_BEEF);
    step(); dm_req = 0;

    // simultaneous requests
    step();
    if_addr = 12'h008; dm_addr = 12'h00C; dm_we = 0;
    if_req = 1; dm_req = 1;
    wait_any(g, n);
    check("t3_first_dm", g, 1);
    step(); dm_req = 0;
    wait_any(g, n);
    check("t3_then_if", g, 0);
    check("t3_if_gap", n, LAT + 1);
    step(); if_req = 0;
    step();
    if_req = 1; dm_req = 1;
    wait_any(g, n);
    check("t3b_first_dm", g, 1);
    step(); dm_addr = 12'h014;
    wait_any(g, n);
    check("t3b_rr", g, RR ? 0 : 1);
    step();
    if (g) dm_req = 0; else if_req = 0;
    wait_any(g, n);
    step(); if_req = 0; dm_req = 0;

    // reset during an in-flight store
    step();
    dm_addr = 12'h020; dm_wdata = 32'h1234_5678; dm_we = 1; dm_req = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1; dm_req = 0; dm_we = 0;
    @(negedge clk);
    check("t4_we", mem_we, 0);
    check("t4_busy", busy, 0);
    check("t4_acks", {if_ack, dm_ack}, 0);
    check("t4_addr", mem_addr, 0);
    check("t4_din", mem_din, 0);
    check("t4_rdata", {if_rdata, dm_rdata}, 0);
    step(); rst = 0;
    step();
    check("t4_mem", mem[8], 32'hA5A5_0008);
    if_addr = 12'h020; if_req = 1;
    wait_any(g, n);
    check("t4_fetch_lat", n, LAT + 1);
    check("t4_fetch", if_rdata, 32'hA5A5_0008);
    step(); if_req = 0;

    // data request arriving while a fetch is busy
    step();
    if_addr = 12'h000; if_req = 1;
    step(); step();
    dm_addr = 12'h00C; dm_we = 0; dm_req = 1;
    wait_any(g, n);
    check("t5_fetch_first", g, 0);
    gap = 0;
    @(negedge clk);
    while (!busy && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    check("t5_bubble", gap, 1);
    wait_any(g, n);
    check("t5_dm_next", g, 1);
    step(); dm_req = 0;
    wait_any(g, n);
    step(); if_req = 0;

    // random traffic
    repeat (1500) begin
      @(negedge clk);
      ia = if_ack; da = dm_ack;
      @(posedge clk);
      #1;
      if (!if_req || ia) begin
        if ($urandom_range(0, 3) != 0) begin
          if_req = 1;
          if_addr = 12'($urandom_range(0, 15) * 4);
        end else if_req = 0;
      end
      if (!dm_req || da) begin
        if ($urandom_range(0, 2) != 0) begin
          dm_req = 1;
          dm_we = 1'($urandom_range(0, 1));
          dm_mode = 2'($urandom_range(0, 2));
          dm_addr = 12'($urandom_range(0, 15) * 4);
          dm_wdata = $urandom;
        end else dm_req = 0;
      end
    end
    step(); if_req = 0; dm_req = 0;
    repeat (12) step();
    for (int i = 0; i < 16; i++)
      check("mem_final", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
